// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 selection tables, key-schedule shift
// amounts and the scheduler state type.
package des_pkg;

    localparam int KS_ROUNDS = 16;
    localparam int CD_W      = 56;
    localparam int HALF_W    = 28;

    typedef logic [47:0] round_key_t;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } ks_state_t;

    // Table entries use DES 1-based bit numbering (bit 1 = MSB).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // SHIFTS[r-1] is the left-rotation amount S[r] for round r.
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [CD_W-1:0] pc1_select(input logic [63:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < CD_W; i++) begin
            cd[CD_W-1-i] = key[64-PC1[i]];
        end
        return cd;
    endfunction

endpackage

// File: rtl/des_pc2_select.sv
// Combinational PC-2 permutation: 56-bit {C,D} to a 48-bit round key.
module des_pc2_select
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] rk
);

    // PC-2 drops DES positions 9, 18, 22, 25, 35, 38, 43 and 54.
    logic unused_dropped;
    assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                              cd[21], cd[18], cd[13], cd[2]};

    always_comb begin
        rk = '0;
        for (int i = 0; i < 48; i++) begin
            rk[47-i] = cd[56-PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key scheduler: one round key per accepted handshake, with
// decrypt order generated by right rotation instead of stored keys.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int KEY_W  = 64,
    parameter int RK_W   = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              decrypt,
    input  logic              key_valid,
    output logic              key_ready,
    output logic [RK_W-1:0]   rk_out,
    output logic [3:0]        rk_idx,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic              done
);

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input int n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input int n);
        return (x >> n) | (x << (HALF_W - n));
    endfunction

    ks_state_t         state_p1, state_p0;
    logic              mode_p1;
    logic [HALF_W-1:0] c_p1, d_p1, c_p0, d_p0;
    round_key_t        rk_p1, rk_p0;
    logic [3:0]        idx_p1;
    logic              done_p1;
    logic              load, advance, finish;
    logic [CD_W-1:0]   cd_init;
    int                sh_enc, sh_dec;

    // Parity bits (DES bits 8, 16, ..., 64) take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign cd_init = pc1_select(key_in);

    // Encrypt steps forward by S[p+2]; decrypt steps backward by S[16-p]. The
    // final decrypt step (S[1]) brings C,D back to C0,D0 like the encrypt path.
    always_comb begin
        sh_enc = (idx_p1 == 4'(ROUNDS - 1)) ? 0 : SHIFTS[int'(idx_p1) + 1];
        sh_dec = SHIFTS[(ROUNDS - 1) - int'(idx_p1)];
    end

    always_comb begin
        state_p0  = state_p1;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        c_p0      = c_p1;
        d_p0      = d_p1;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        case (state_p1)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load     = 1'b1;
                    state_p0 = GEN;
                    if (decrypt) begin
                        c_p0 = cd_init[CD_W-1:HALF_W];
                        d_p0 = cd_init[HALF_W-1:0];
                    end else begin
                        c_p0 = rotl28(cd_init[CD_W-1:HALF_W], SHIFTS[0]);
                        d_p0 = rotl28(cd_init[HALF_W-1:0], SHIFTS[0]);
                    end
                end
            end
            GEN: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (idx_p1 == 4'(ROUNDS - 1)) begin
                        finish   = 1'b1;
                        state_p0 = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                    if (mode_p1) begin
                        c_p0 = rotr28(c_p1, sh_dec);
                        d_p0 = rotr28(d_p1, sh_dec);
                    end else begin
                        c_p0 = rotl28(c_p1, sh_enc);
                        d_p0 = rotl28(d_p1, sh_enc);
                    end
                end
            end
            default: state_p0 = IDLE;
        endcase
    end

    des_pc2_select u_pc2 (
        .cd ({c_p0, d_p0}),
        .rk (rk_p0)
    );

    // Stage p0 -> p1: register rotated halves and the new round key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= IDLE;
            mode_p1  <= 1'b0;
            c_p1     <= '0;
            d_p1     <= '0;
            rk_p1    <= '0;
            idx_p1   <= '0;
            done_p1  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            done_p1  <= finish;
            c_p1     <= c_p0;
            d_p1     <= d_p0;
            if (load) begin
                mode_p1 <= decrypt;
                rk_p1   <= rk_p0;
                idx_p1  <= '0;
            end else if (advance) begin
                rk_p1  <= rk_p0;
                idx_p1 <= idx_p1 + 4'd1;
            end
        end
    end

    assign rk_out = rk_p1;
    assign rk_idx = idx_p1;
    assign done   = done_p1;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule against a table-driven DES key model.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] rk_out;
    logic [3:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [47:0] exp_rk [16];
    logic [47:0] obs_rk [16];
    logic [47:0] enc_rk [16];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // K_r = PC2(C0,D0 each rotated left by S[1]+..+S[r]); decrypt lists them reversed.
    task automatic model(input logic [63:0] key, input logic dec);
        bit          c0 [28];
        bit          d0 [28];
        bit          cd [56];
        logic [47:0] k  [16];
        int          tot;
        for (int i = 0; i < 28; i++) begin
            c0[i] = key[64-PC1_T[i]];
            d0[i] = key[64-PC1_T[i+28]];
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SH_T[r];
            for (int j = 0; j < 28; j++) begin
                cd[j]    = c0[(j + tot) % 28];
                cd[j+28] = d0[(j + tot) % 28];
            end
            k[r] = '0;
            for (int i = 0; i < 48; i++) k[r][47-i] = cd[PC2_T[i]-1];
        end
        for (int p = 0; p < 16; p++) exp_rk[p] = dec ? k[15-p] : k[p];
    endtask

    task automatic load(input logic [63:0] key, input logic dec);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // mode: 0 ready held, 1 random ready, 2 five-cycle stall at idx 7,
    //       3 random ready plus reload attempts, 4 reset at idx 9
    task automatic collect(input int mode, input string nm);
        int count = 0;
        int cyc   = 0;
        int stall = 0;
        while (count < 16 && cyc < 400) begin
            if (mode == 4 && count == 9) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check({nm, "_rk_valid"}, 64'(rk_valid), 64'd0);
                check({nm, "_key_ready"}, 64'(key_ready), 64'd1);
                check({nm, "_rk_idx"}, 64'(rk_idx), 64'd0);
                check({nm, "_done"}, 64'(done), 64'd0);
                return;
            end
            check({nm, "_rk_valid"}, 64'(rk_valid), 64'd1);
            check({nm, "_key_ready"}, 64'(key_ready), 64'd0);
            check({nm, "_done_early"}, 64'(done), 64'd0);
            check({nm, "_rk_idx"}, 64'(rk_idx), 64'(count));
            check({nm, "_rk_out"}, 64'(rk_out), 64'(exp_rk[count]));
            obs_rk[count] = rk_out;
            case (mode)
                1, 3: rk_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (count == 7 && stall < 5) begin
                        rk_ready = 1'b0;
                        stall++;
                    end else begin
                        rk_ready = 1'b1;
                    end
                end
                default: rk_ready = 1'b1;
            endcase
            if (mode == 3) begin
                key_valid = 1'b1;
                key_in    = {$urandom, $urandom};
                decrypt   = 1'($urandom_range(0, 1));
            end
            tick();
            if (rk_ready) count++;
            cyc++;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        check({nm, "_key_count"}, 64'(count), 64'd16);
        check({nm, "_done"}, 64'(done), 64'd1);
        check({nm, "_end_valid"}, 64'(rk_valid), 64'd0);
        check({nm, "_end_ready"}, 64'(key_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] k;
        logic        d;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        decrypt   = 1'b0;
        rk_ready  = 1'b0;
        tick();
        tick();
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_rk_valid", 64'(rk_valid), 64'd0);
        check("rst_rk_out", 64'(rk_out), 64'd0);
        check("rst_rk_idx", 64'(rk_idx), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst      = 1'b0;
        rk_ready = 1'b1;
        tick();

        model(KEY_A, 1'b0);
        load(KEY_A, 1'b0);
        collect(0, "enc");
        enc_rk = obs_rk;
        check("enc_k1", 64'(enc_rk[0]), 64'h1B02EFFC7072);
        check("enc_k16", 64'(enc_rk[15]), 64'hCB3D8B0E17F5);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);

        model(KEY_A, 1'b1);
        load(KEY_A, 1'b1);
        collect(0, "dec");
        check("dec_first", 64'(obs_rk[0]), 64'hCB3D8B0E17F5);
        check("dec_last", 64'(obs_rk[15]), 64'h1B02EFFC7072);
        for (int p = 0; p < 16; p++) check("dec_reversed", 64'(obs_rk[p]), 64'(enc_rk[15-p]));
        tick();

        model(KEY_A, 1'b0);
        load(KEY_A, 1'b0);
        collect(2, "stall");
        tick();

        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            model(k, d);
            load(k, d);
            collect(1, "rand_bp");
            tick();
        end

        k = {$urandom, $urandom};
        model(k, 1'b1);
        load(k, 1'b1);
        collect(3, "reload_ignored");
        tick();

        model(KEY_A, 1'b0);
        load(KEY_A, 1'b0);
        collect(4, "rst_mid");
        load(KEY_A, 1'b0);
        collect(0, "after_rst");

        k = {$urandom, $urandom};
        model(k, 1'b1);
        load(k, 1'b1);
        collect(0, "b2b_second");
        k = {$urandom, $urandom};
        model(k, 1'b0);
        load(k, 1'b0);
        collect(1, "b2b_third");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
